// File: rtl/rsa_pipe_pkg.sv
// Shared types for the RSA pipeline execute stage: lane geometry, ALU opcodes, EX FSM states.
package rsa_pipe_pkg;

    localparam int unsigned LANES = 6;
    localparam int unsigned W     = 8;

    typedef logic [W-1:0]      lane_t;
    typedef lane_t [LANES-1:0] vec_t;

    // Code 3'b111 is MOD when EX_MOD_EN is defined, otherwise single-cycle MOVB
    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SHL = 3'b101,
        OP_MUL = 3'b110,
        OP_MOD = 3'b111
    } alu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } ex_state_e;

endpackage

// File: rtl/ex_vector_alu_stage_if.sv
// ID/EX inputs and EX/MEM outputs of the vector execute stage.
interface ex_vector_alu_stage_if;
    import rsa_pipe_pkg::*;

    logic       RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, FlagsWriteE;
    logic [2:0] ALUControlE;
    logic [3:0] WA3E;
    vec_t       rd1E, rd2E;
    lane_t      ExtImmE;

    logic       RegWriteM, MemtoRegM, MemWriteM;
    logic [3:0] WA3M;
    vec_t       ALUResultM, WriteDataM;
    logic [1:0] FlagsM;
    logic       stallE, busyE;

    modport master (
        output RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, FlagsWriteE,
               ALUControlE, WA3E, rd1E, rd2E, ExtImmE,
        input  RegWriteM, MemtoRegM, MemWriteM, WA3M, ALUResultM, WriteDataM,
               FlagsM, stallE, busyE
    );

    modport slave (
        input  RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, FlagsWriteE,
               ALUControlE, WA3E, rd1E, rd2E, ExtImmE,
        output RegWriteM, MemtoRegM, MemWriteM, WA3M, ALUResultM, WriteDataM,
               FlagsM, stallE, busyE
    );

endinterface

// File: rtl/ex_vector_alu_stage_lane_seq_muldiv.sv
// One lane of the iterative MUL (shift-add) / MOD (restoring) datapath; MOD only with EX_MOD_EN.
module lane_seq_muldiv
    import rsa_pipe_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       step,
`ifdef EX_MOD_EN
    input  logic       op_mod,
`endif
    input  logic [2:0] cnt,
    input  lane_t      a,
    input  lane_t      b,
    output lane_t      res
);
    lane_t a_q, b_q, acc_q, acc_d, partial;
`ifdef EX_MOD_EN
    logic [W:0] rem_sh;
`endif

    // res is the accumulator after the current iteration, so the last step's value is usable on its edge
    always_comb begin
        partial = b_q[cnt] ? lane_t'(a_q << cnt) : '0;
        acc_d   = acc_q + partial;
`ifdef EX_MOD_EN
        rem_sh = {acc_q, a_q[3'(W - 1) - cnt]};
        if (op_mod) begin
            acc_d = (rem_sh >= {1'b0, b_q}) ? lane_t'(rem_sh - {1'b0, b_q}) : rem_sh[W-1:0];
        end
`endif
    end

    assign res = acc_d;

    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
        end else if (start) begin
            a_q   <= a;
            b_q   <= b;
            acc_q <= '0;
        end else if (step) begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/ex_vector_alu_stage.sv
// Vector execute stage: single-cycle lane ALU plus 8-iteration MUL/MOD with stall.
// Macro EX_MOD_EN selects iterative MOD for code 111; otherwise 111 is single-cycle MOVB.
module ex_vector_alu_stage
    import rsa_pipe_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    ex_vector_alu_stage_if.slave  bus
);
    ex_state_e  state_q, state_d;
    logic [2:0] cnt_q;
    alu_op_e    op_e;
    logic       rw_q, m2r_q, mw_q, fw_q;
    logic [3:0] wa3_q;
    vec_t       wd_q, opb, sc_res, seq_res;
    logic [W:0] sum, dif;
    logic       sc_c, sc_z, seq_z, is_multi, start, step, last, stall;
`ifdef EX_MOD_EN
    alu_op_e    op_q;
`endif

    assign op_e = alu_op_e'(bus.ALUControlE);
    assign opb  = bus.ALUSrcE ? {LANES{bus.ExtImmE}} : bus.rd2E;

`ifdef EX_MOD_EN
    assign is_multi = (op_e == OP_MUL) || (op_e == OP_MOD);
`else
    assign is_multi = (op_e == OP_MUL);
`endif

    always_comb begin
        sc_res = '0;
        sc_c   = 1'b0;
        sum    = '0;
        dif    = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            sum = {1'b0, bus.rd1E[i]} + {1'b0, opb[i]};
            dif = {1'b0, bus.rd1E[i]} - {1'b0, opb[i]};
            case (op_e)
                OP_ADD: begin sc_res[i] = sum[W-1:0]; sc_c = sc_c | sum[W]; end
                OP_SUB: begin sc_res[i] = dif[W-1:0]; sc_c = sc_c | dif[W]; end
                OP_AND: sc_res[i] = bus.rd1E[i] & opb[i];
                OP_OR:  sc_res[i] = bus.rd1E[i] | opb[i];
                OP_XOR: sc_res[i] = bus.rd1E[i] ^ opb[i];
                OP_SHL: sc_res[i] = bus.rd1E[i] << opb[i][2:0];
`ifndef EX_MOD_EN
                OP_MOD: sc_res[i] = opb[i];
`endif
                default: sc_res[i] = '0;
            endcase
        end
        sc_z = (sc_res == '0);
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        lane_seq_muldiv u_lane (
            .clk    (clk),
            .reset  (reset),
            .start  (start),
            .step   (step),
`ifdef EX_MOD_EN
            .op_mod (op_q == OP_MOD),
`endif
            .cnt    (cnt_q),
            .a      (bus.rd1E[g]),
            .b      (opb[g]),
            .res    (seq_res[g])
        );
    end

    assign seq_z = (seq_res == '0);

    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        start   = 1'b0;
        step    = 1'b0;
        last    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (is_multi) begin
                    start   = 1'b1;
                    stall   = 1'b1;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                step = 1'b1;
                if (cnt_q == 3'd7) begin
                    last    = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Gated so the hazard unit never sees a stall while the pipe is held in reset
    assign bus.stallE = stall & ~reset;
    assign bus.busyE  = (state_q == ST_BUSY);

    always_ff @(negedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            cnt_q          <= '0;
            rw_q           <= 1'b0;
            m2r_q          <= 1'b0;
            mw_q           <= 1'b0;
            fw_q           <= 1'b0;
            wa3_q          <= '0;
            wd_q           <= '0;
`ifdef EX_MOD_EN
            op_q           <= OP_ADD;
`endif
            bus.RegWriteM  <= 1'b0;
            bus.MemtoRegM  <= 1'b0;
            bus.MemWriteM  <= 1'b0;
            bus.WA3M       <= '0;
            bus.ALUResultM <= '0;
            bus.WriteDataM <= '0;
            bus.FlagsM     <= '0;
        end else if (start) begin
            cnt_q         <= '0;
            rw_q          <= bus.RegWriteE;
            m2r_q         <= bus.MemtoRegE;
            mw_q          <= bus.MemWriteE;
            fw_q          <= bus.FlagsWriteE;
            wa3_q         <= bus.WA3E;
            wd_q          <= bus.rd2E;
`ifdef EX_MOD_EN
            op_q          <= op_e;
`endif
            bus.RegWriteM <= 1'b0;
            bus.MemtoRegM <= 1'b0;
            bus.MemWriteM <= 1'b0;
        end else if (step) begin
            cnt_q <= cnt_q + 3'd1;
            if (last) begin
                bus.RegWriteM  <= rw_q;
                bus.MemtoRegM  <= m2r_q;
                bus.MemWriteM  <= mw_q;
                bus.WA3M       <= wa3_q;
                bus.ALUResultM <= seq_res;
                bus.WriteDataM <= wd_q;
                if (fw_q) bus.FlagsM <= {seq_z, 1'b0};
            end
        end else begin
            bus.RegWriteM  <= bus.RegWriteE;
            bus.MemtoRegM  <= bus.MemtoRegE;
            bus.MemWriteM  <= bus.MemWriteE;
            bus.WA3M       <= bus.WA3E;
            bus.ALUResultM <= sc_res;
            bus.WriteDataM <= bus.rd2E;
            if (bus.FlagsWriteE) bus.FlagsM <= {sc_z, sc_c};
        end
    end

endmodule

// File: tb/tb_ex_vector_alu_stage.sv
// Directed bench for ex_vector_alu_stage: ALU ops, flags, MUL/MOD iteration, stall, reset abort.
module tb_ex_vector_alu_stage;
    import rsa_pipe_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    ex_vector_alu_stage_if bus ();

    ex_vector_alu_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic rw, input logic fw, input logic src,
                         input logic [3:0] wa, input vec_t a, input vec_t b, input lane_t imm);
        bus.ALUControlE = op;
        bus.RegWriteE   = rw;
        bus.MemtoRegE   = 1'b0;
        bus.MemWriteE   = 1'b0;
        bus.FlagsWriteE = fw;
        bus.ALUSrcE     = src;
        bus.WA3E        = wa;
        bus.rd1E        = a;
        bus.rd2E        = b;
        bus.ExtImmE     = imm;
    endtask

    task automatic bubble;
        drive(3'b000, 1'b0, 1'b0, 1'b0, 4'h0, '0, '0, '0);
    endtask

    task automatic test_reset;
        bubble();
        #1 reset = 1'b1;
        #2;
        n_cmp++; if (bus.RegWriteM !== 1'b0) begin n_bad++; $display("FAIL reset_regwrite got %h want 0", bus.RegWriteM); end
        n_cmp++; if (bus.ALUResultM !== '0) begin n_bad++; $display("FAIL reset_result got %h want 0", bus.ALUResultM); end
        n_cmp++; if (bus.FlagsM !== 2'b00) begin n_bad++; $display("FAIL reset_flags got %b want 00", bus.FlagsM); end
        n_cmp++; if (bus.stallE !== 1'b0) begin n_bad++; $display("FAIL reset_stall got %b want 0", bus.stallE); end
        n_cmp++; if (bus.busyE !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", bus.busyE); end
        tick();
        reset = 1'b0;
    endtask

    task automatic test_add;
        vec_t a, b, e;
        a = {8'hFF, {5{8'h01}}};
        b = {6{8'h01}};
        e = {8'h00, {5{8'h02}}};
        drive(3'b000, 1'b1, 1'b1, 1'b0, 4'h3, a, b, 8'h00);
        bus.MemtoRegE = 1'b1;
        bus.MemWriteE = 1'b1;
        #1;
        n_cmp++; if (bus.stallE !== 1'b0) begin n_bad++; $display("FAIL add_stall got %b want 0", bus.stallE); end
        tick();
        n_cmp++; if (bus.ALUResultM !== e) begin n_bad++; $display("FAIL add_result got %h want %h", bus.ALUResultM, e); end
        n_cmp++; if (bus.FlagsM !== 2'b01) begin n_bad++; $display("FAIL add_flags got %b want 01", bus.FlagsM); end
        n_cmp++; if (bus.RegWriteM !== 1'b1) begin n_bad++; $display("FAIL add_regwrite got %b want 1", bus.RegWriteM); end
        n_cmp++; if (bus.WA3M !== 4'h3) begin n_bad++; $display("FAIL add_wa3 got %h want 3", bus.WA3M); end
        n_cmp++; if (bus.WriteDataM !== b) begin n_bad++; $display("FAIL add_wdata got %h want %h", bus.WriteDataM, b); end
        n_cmp++; if ({bus.MemtoRegM, bus.MemWriteM} !== 2'b11) begin n_bad++; $display("FAIL add_memctl got %b want 11", {bus.MemtoRegM, bus.MemWriteM}); end
    endtask

    task automatic test_sub;
        drive(3'b001, 1'b1, 1'b1, 1'b0, 4'h4, {6{8'h05}}, {6{8'h05}}, 8'h00);
        tick();
        n_cmp++; if (bus.ALUResultM !== '0) begin n_bad++; $display("FAIL sub_zero_result got %h want 0", bus.ALUResultM); end
        n_cmp++; if (bus.FlagsM !== 2'b10) begin n_bad++; $display("FAIL sub_zero_flags got %b want 10", bus.FlagsM); end
        drive(3'b001, 1'b1, 1'b1, 1'b0, 4'h4, {6{8'h01}}, {6{8'h02}}, 8'h00);
        tick();
        n_cmp++; if (bus.ALUResultM !== {6{8'hFF}}) begin n_bad++; $display("FAIL sub_borrow_result got %h want all FF", bus.ALUResultM); end
        n_cmp++; if (bus.FlagsM !== 2'b01) begin n_bad++; $display("FAIL sub_borrow_flags got %b want 01", bus.FlagsM); end
    endtask

    task automatic test_logic;
        logic [2:0] ops [4];
        lane_t      exp [4];
        lane_t      e;
        ops = '{3'b010, 3'b011, 3'b100, 3'b101};
        exp = '{8'h03, 8'hCF, 8'hCC, 8'h80};
        for (int unsigned k = 0; k < 4; k++) begin
            drive(ops[k], 1'b1, 1'b0, 1'b0, 4'h6, {6{8'hC3}}, {6{8'h0F}}, 8'h00);
            tick();
            e = exp[k];
            n_cmp++; if (bus.ALUResultM !== {LANES{e}}) begin n_bad++; $display("FAIL logic_op%0d_result got %h want all %h", ops[k], bus.ALUResultM, e); end
            n_cmp++; if (bus.FlagsM !== 2'b01) begin n_bad++; $display("FAIL logic_op%0d_flags_held got %b want 01", ops[k], bus.FlagsM); end
        end
        bubble();
        tick();
        n_cmp++; if (bus.RegWriteM !== 1'b0) begin n_bad++; $display("FAIL bubble_regwrite got %b want 0", bus.RegWriteM); end
        n_cmp++; if (bus.FlagsM !== 2'b01) begin n_bad++; $display("FAIL bubble_flags got %b want 01", bus.FlagsM); end
    endtask

    task automatic test_mul;
        drive(3'b110, 1'b1, 1'b1, 1'b1, 4'h5, {6{8'h05}}, {6{8'hAA}}, 8'h03);
        for (int unsigned i = 0; i < 9; i++) begin
            #1;
            n_cmp++; if (bus.stallE !== (i < 8)) begin n_bad++; $display("FAIL mul_stall_c%0d got %b want %b", i, bus.stallE, (i < 8)); end
            tick();
            if (i == 0) begin
                bus.rd1E    = '1;
                bus.rd2E    = '0;
                bus.ExtImmE = 8'h77;
            end
            n_cmp++; if (bus.RegWriteM !== (i == 8)) begin n_bad++; $display("FAIL mul_regwrite_e%0d got %b want %b", i + 1, bus.RegWriteM, (i == 8)); end
            n_cmp++; if (bus.busyE !== (i < 8)) begin n_bad++; $display("FAIL mul_busy_e%0d got %b want %b", i + 1, bus.busyE, (i < 8)); end
        end
        n_cmp++; if (bus.ALUResultM !== {6{8'h0F}}) begin n_bad++; $display("FAIL mul_result got %h want all 0F", bus.ALUResultM); end
        n_cmp++; if (bus.FlagsM !== 2'b00) begin n_bad++; $display("FAIL mul_flags got %b want 00", bus.FlagsM); end
        n_cmp++; if (bus.WA3M !== 4'h5) begin n_bad++; $display("FAIL mul_wa3 got %h want 5", bus.WA3M); end
        n_cmp++; if (bus.WriteDataM !== {6{8'hAA}}) begin n_bad++; $display("FAIL mul_wdata got %h want all AA", bus.WriteDataM); end
        bubble();
        tick();
        n_cmp++; if (bus.RegWriteM !== 1'b0) begin n_bad++; $display("FAIL mul_after_regwrite got %b want 0", bus.RegWriteM); end
    endtask

    task automatic test_back_to_back;
        drive(3'b110, 1'b1, 1'b0, 1'b1, 4'h9, {6{8'h02}}, '0, 8'h04);
        for (int unsigned i = 0; i < 8; i++) begin
            tick();
            n_cmp++; if (bus.RegWriteM !== 1'b0) begin n_bad++; $display("FAIL b2b_mul_bubble_e%0d got %b want 0", i + 1, bus.RegWriteM); end
        end
        tick();
        n_cmp++; if (bus.RegWriteM !== 1'b1 || bus.WA3M !== 4'h9) begin n_bad++; $display("FAIL b2b_mul_write got rw=%b wa=%h want rw=1 wa=9", bus.RegWriteM, bus.WA3M); end
        n_cmp++; if (bus.ALUResultM !== {6{8'h08}}) begin n_bad++; $display("FAIL b2b_mul_result got %h want all 08", bus.ALUResultM); end
        drive(3'b000, 1'b1, 1'b1, 1'b0, 4'hA, {6{8'h80}}, {6{8'h80}}, 8'h00);
        tick();
        n_cmp++; if (bus.RegWriteM !== 1'b1 || bus.WA3M !== 4'hA) begin n_bad++; $display("FAIL b2b_add_write got rw=%b wa=%h want rw=1 wa=A", bus.RegWriteM, bus.WA3M); end
        n_cmp++; if (bus.ALUResultM !== '0) begin n_bad++; $display("FAIL b2b_add_result got %h want 0", bus.ALUResultM); end
        n_cmp++; if (bus.FlagsM !== 2'b11) begin n_bad++; $display("FAIL b2b_add_flags got %b want 11", bus.FlagsM); end
        bubble();
        tick();
        n_cmp++; if (bus.RegWriteM !== 1'b0) begin n_bad++; $display("FAIL b2b_no_dup got %b want 0", bus.RegWriteM); end
    endtask

`ifdef EX_MOD_EN
    task automatic test_mod;
        vec_t b, e;
        b = {8'd5, 8'd200, 8'd0, 8'd1, 8'd3, 8'd17};
        e = {8'd2, 8'd17, 8'd17, 8'd0, 8'd2, 8'd0};
        drive(3'b111, 1'b1, 1'b1, 1'b0, 4'h7, {6{8'd17}}, b, 8'h00);
        for (int unsigned i = 0; i < 9; i++) begin
            #1;
            n_cmp++; if (bus.stallE !== (i < 8)) begin n_bad++; $display("FAIL mod_stall_c%0d got %b want %b", i, bus.stallE, (i < 8)); end
            tick();
        end
        n_cmp++; if (bus.ALUResultM !== e) begin n_bad++; $display("FAIL mod_result got %h want %h", bus.ALUResultM, e); end
        n_cmp++; if (bus.FlagsM !== 2'b00) begin n_bad++; $display("FAIL mod_flags got %b want 00", bus.FlagsM); end
        n_cmp++; if (bus.RegWriteM !== 1'b1) begin n_bad++; $display("FAIL mod_regwrite got %b want 1", bus.RegWriteM); end
        bubble();
        tick();
    endtask
`else
    task automatic test_movb;
        drive(3'b111, 1'b1, 1'b1, 1'b0, 4'h8, {6{8'h55}}, {6{8'h33}}, 8'h00);
        #1;
        n_cmp++; if (bus.stallE !== 1'b0) begin n_bad++; $display("FAIL movb_stall got %b want 0", bus.stallE); end
        tick();
        n_cmp++; if (bus.ALUResultM !== {6{8'h33}}) begin n_bad++; $display("FAIL movb_result got %h want all 33", bus.ALUResultM); end
        n_cmp++; if (bus.busyE !== 1'b0 || bus.stallE !== 1'b0) begin n_bad++; $display("FAIL movb_busy_stall got %b%b want 00", bus.busyE, bus.stallE); end
        n_cmp++; if (bus.FlagsM !== 2'b00) begin n_bad++; $display("FAIL movb_flags got %b want 00", bus.FlagsM); end
        bubble();
        tick();
    endtask
`endif

    task automatic test_reset_mid;
        drive(3'b000, 1'b1, 1'b1, 1'b0, 4'hC, {6{8'h80}}, {6{8'h81}}, 8'h00);
        tick();
        drive(3'b110, 1'b1, 1'b1, 1'b1, 4'hB, {6{8'h03}}, '0, 8'h03);
        for (int unsigned i = 0; i < 5; i++) tick();
        n_cmp++; if (bus.busyE !== 1'b1) begin n_bad++; $display("FAIL rmid_busy_before got %b want 1", bus.busyE); end
        reset = 1'b1;
        #1;
        n_cmp++; if (bus.ALUResultM !== '0) begin n_bad++; $display("FAIL rmid_result got %h want 0", bus.ALUResultM); end
        n_cmp++; if (bus.FlagsM !== 2'b00) begin n_bad++; $display("FAIL rmid_flags got %b want 00", bus.FlagsM); end
        n_cmp++; if (bus.WA3M !== 4'h0 || bus.WriteDataM !== '0) begin n_bad++; $display("FAIL rmid_wa3_wdata got %h/%h want 0/0", bus.WA3M, bus.WriteDataM); end
        n_cmp++; if (bus.busyE !== 1'b0 || bus.stallE !== 1'b0) begin n_bad++; $display("FAIL rmid_busy_stall got %b%b want 00", bus.busyE, bus.stallE); end
        tick();
        reset = 1'b0;
        drive(3'b000, 1'b1, 1'b1, 1'b0, 4'hD, {6{8'h10}}, {6{8'h20}}, 8'h00);
        #1;
        n_cmp++; if (bus.stallE !== 1'b0) begin n_bad++; $display("FAIL rmid_add_stall got %b want 0", bus.stallE); end
        tick();
        n_cmp++; if (bus.ALUResultM !== {6{8'h30}} || bus.RegWriteM !== 1'b1) begin n_bad++; $display("FAIL rmid_add got %h rw=%b want all 30 rw=1", bus.ALUResultM, bus.RegWriteM); end
        bubble();
        for (int unsigned i = 0; i < 9; i++) begin
            tick();
            n_cmp++; if (bus.RegWriteM !== 1'b0) begin n_bad++; $display("FAIL rmid_no_partial_e%0d got %b want 0", i, bus.RegWriteM); end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_logic();
        test_mul();
        test_back_to_back();
`ifdef EX_MOD_EN
        test_mod();
`else
        test_movb();
`endif
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ex_vector_alu_stage.md
# ex_vector_alu_stage

Execute stage of the RSA pipeline CPU. It consumes the ID/EX segment outputs: control, destination, two 6-lane × 8-bit operand vectors and the extended immediate. It produces the EX/MEM bundle, a lane-wise ALU result and a Z/C flags register. Single-cycle ops complete at the next capture edge. Multi-cycle MUL and MOD iterate for 8 edges and assert `stallE` so the hazard logic holds the ID/EX segment and earlier stages.

## Interface
- `LANES`, 6, number of vector lanes
- `W`, 8, lane width in bits
- `clk` in 1: pipeline clock; all state captured on negedge, matching the segment registers
- `reset` in 1: reset, asynchronous, active-high
- `RegWriteE`, `MemtoRegE`, `MemWriteE`, `ALUSrcE`, `FlagsWriteE` in 1 each: ID/EX control
- `ALUControlE` in 3: operation code
- `WA3E` in 4: destination register
- `rd1E`, `rd2E` in LANES×W: operand vectors
- `ExtImmE` in W: immediate
- `RegWriteM`, `MemtoRegM`, `MemWriteM` out 1 each: registered control to EX/MEM
- `WA3M` out 4: registered destination
- `ALUResultM` out LANES×W: registered result
- `WriteDataM` out LANES×W: registered `rd2E`
- `FlagsM` out 2: flags register, bit 1 = Z, bit 0 = C
- `stallE` out 1: combinational; hold ID/EX and earlier stages
- `busyE` out 1: registered; FSM is in BUSY

## Operation
- Operand B = `ALUSrcE ? {LANES{ExtImmE}} : rd2E`. Every lane is independent.
- 000 ADD: lane sum mod 2^W.
- 001 SUB: a − b mod 2^W.
- 010 AND, 011 OR, 100 XOR.
- 101 SHL: a << b[2:0].
- 110 MUL: low W bits of a×b, shift-add, 8 iterations.
- 111 MOD: a mod b, restoring, 8 iterations; b = 0 yields a.
- Flags are written only when `FlagsWriteE` is set, at the edge the result is written.
  - Z = all result lanes zero.
  - C = OR of lane carry-outs for ADD, OR of lane borrows for SUB, 0 otherwise.
- FSM states IDLE and BUSY.
  - IDLE with a single-cycle op or bubble: EX/MEM ← computed bundle.
  - IDLE with op 110/111: latch operands, op, control and destination; cnt ← 0; → BUSY; EX/MEM control ← 0 (bubble).
  - BUSY, cnt < 7: one iteration; cnt++; EX/MEM control held at 0.
  - BUSY, cnt = 7: final iteration; EX/MEM ← latched control, destination, final result; flags update; → IDLE.
- `stallE` = (IDLE ∧ op ∈ {110,111}) ∨ (BUSY ∧ cnt ≠ 7).
- ID/EX inputs are ignored while BUSY; the latched copy is used.

## Timing
- Reset values: all EX/MEM outputs 0, `FlagsM` = 0, `stallE` = 0, `busyE` = 0, state IDLE, cnt 0.
- Single-cycle op: result on EX/MEM one negedge after it appears on ID/EX outputs.
- Multi-cycle op: `stallE` is high for 8 cycles (accept cycle plus cnt 0..6) and low during cnt = 7. The result appears at the 9th negedge, the same edge at which ID/EX loads the next instruction. Back-to-back multi-cycle ops therefore incur no idle gap.
- A bubble (all control 0) writes a zero-control bundle; flags are untouched.
- Reset asserted mid-BUSY aborts immediately to the reset values. No partial result is ever issued.

## Configuration
- `EX_MOD_EN` defined: 111 = iterative MOD, as above.
- `EX_MOD_EN` undefined: 111 = single-cycle MOVB (result = operand B), never stalls. The MOD datapath is not synthesized.

## Structure
- Package `rsa_pipe_pkg` holds:
  - `LANES` and `W` constants;
  - `lane_t` (logic [W-1:0]) and `vec_t` (lane_t [LANES-1:0]);
  - the `alu_op_e` enum for the 3-bit codes;
  - the FSM state enum.
- One sub-module, `lane_seq_muldiv`: one lane's iterative MUL/MOD datapath, driven by start/op/cnt. It is instantiated LANES times.

## Test plan
- **ADD:** reset, then ADD with rd1 = {FF,01,…}, rd2 = {01,01,…}, `FlagsWriteE` = 1 → next negedge result {00,02,…}, C = 1, Z = 0.
- **MUL:** `ALUSrcE` = 1, `ExtImmE` = 03, rd1 lanes = 05 → `stallE` high 8 cycles, ninth negedge result lanes = 0F, `RegWriteM` = 1 only on that edge.
- **MOD:** rd1 = {17,…}, rd2 = {05,00,…} → {02,17,…} after 9 edges; Z = 0.
- **Back-to-back:** MUL then ADD → ADD result exactly one negedge after the MUL result; no duplicate writes.
- **Reset mid-op:** assert reset at cnt = 4 → all outputs 0 immediately, `stallE` = 0; a new ADD after release completes normally.
- **`EX_MOD_EN` undefined:** op 111 with `rd2E` = 0x33 → next edge result 0x33, `stallE` never high.
